gfx_rom_arbiter: RTL and testbench

Shares one graphics-ROM read port (SDRAM or BRAM controller) between three requesters: the tilemap fetch path (plane address generator / k051962 pixel feed), CPU ROM readback (RMRD), and the sprite fetch path. The tilemap path has fixed top priority because of its hard per-slot deadline. CPU and sprite requests alternate round-robin. Only one memory access is in flight at any time, and a watchdog recovers the arbiter if the memory never answers.

---
 rtl/gfx_rom_if.sv | 26 ++
 rtl/gfx_rom_arbiter.sv | 175 +++++++++++++++++
 tb/tb_gfx_rom_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gfx_rom_if.sv
// Graphics-ROM arbiter bus: three requester ports (tile, CPU, sprite) plus the shared memory port.
// The arbiter connects as slave; requesters and memory are modelled from the master side.
interface gfx_rom_if #(
    parameter int AW = 21,
    parameter int DW = 32
);
    logic          t_req, c_req, s_req;
    logic [AW-1:0] t_addr, c_addr, s_addr;
    logic [DW-1:0] t_data, c_data, s_data;
    logic          t_ack, c_ack, s_ack;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rdy;
    logic [DW-1:0] mem_data;
    logic          tmo;

    modport slave (
        input  t_req, t_addr, c_req, c_addr, s_req, s_addr, mem_rdy, mem_data,
        output t_data, t_ack, c_data, c_ack, s_data, s_ack, mem_req, mem_addr, tmo
    );

    modport master (
        output t_req, t_addr, c_req, c_addr, s_req, s_addr, mem_rdy, mem_data,
        input  t_data, t_ack, c_data, c_ack, s_data, s_ack, mem_req, mem_addr, tmo
    );
endinterface

// File: rtl/gfx_rom_arbiter.sv
// Shares one graphics-ROM read port between tile (fixed top priority), CPU and sprite
// requesters (round-robin), one access in flight, with a watchdog and late-reply flush.

// Per-requester return path: data register and one-cycle ack pulse.
module gfx_rom_arb_port #(
    parameter int DW = 32
) (
    input  logic          clk_24M,
    input  logic          nRES,
    input  logic          load,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] data,
    output logic          ack
);
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            data <= '0;
            ack  <= 1'b0;
        end else begin
            ack <= load;
            if (load) data <= din;
        end
    end
endmodule

module gfx_rom_arbiter #(
    parameter int AW      = 21,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input logic       clk_24M,
    input logic       nRES,
    gfx_rom_if.slave  bus
);
    localparam int NUM_PORTS = 3;  // index 0 = tile, 1 = CPU, 2 = sprite

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_T    = 2'd1;
    localparam logic [1:0] G_C    = 2'd2;
    localparam logic [1:0] G_S    = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]                     state;
    logic [1:0]                     gnt;
    logic                           rr;
    logic [7:0]                     cnt;
    logic                           mem_req_q;
    logic [AW-1:0]                  mem_addr_q;
    logic                           tmo_q;

    logic [NUM_PORTS-1:0]           req;
    logic [NUM_PORTS-1:0]           mask;
    logic [NUM_PORTS-1:0]           eff;
    logic [NUM_PORTS-1:0][AW-1:0]   addr;
    logic [NUM_PORTS-1:0][DW-1:0]   data;
    logic [NUM_PORTS-1:0]           ack;
    logic [NUM_PORTS-1:0]           gnt_oh;
    logic [NUM_PORTS-1:0]           load;
    logic [DW-1:0]                  din;
    logic [1:0]                     pick;
    logic [AW-1:0]                  pick_addr;
    logic                           done;

    assign req  = {bus.s_req, bus.c_req, bus.t_req};
    assign addr = {bus.s_addr, bus.c_addr, bus.t_addr};

    // The mask bit is set exactly in the ack cycle and clears one cycle later,
    // which is precisely the ack register, so it is shared rather than duplicated.
    assign mask = ack;
    assign eff  = req & ~mask;

    always_comb begin
        pick      = G_NONE;
        pick_addr = '0;
        if (eff[0]) begin
            pick      = G_T;
            pick_addr = addr[0];
        end else if (eff[1] && (!eff[2] || !rr)) begin
            pick      = G_C;
            pick_addr = addr[1];
        end else if (eff[2]) begin
            pick      = G_S;
            pick_addr = addr[2];
        end
    end

    always_comb begin
        gnt_oh = '0;
        case (gnt)
            G_T:     gnt_oh = 3'b001;
            G_C:     gnt_oh = 3'b010;
            G_S:     gnt_oh = 3'b100;
            default: gnt_oh = '0;
        endcase
    end

    // A WAIT ends either on a reply or when the watchdog expires; both ack the requester.
    assign done = (state == S_WAIT) && (bus.mem_rdy || cnt == CNT_LAST);
    assign load = done ? gnt_oh : '0;
    assign din  = bus.mem_rdy ? bus.mem_data : '1;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        gfx_rom_arb_port #(.DW(DW)) u_port (
            .clk_24M (clk_24M),
            .nRES    (nRES),
            .load    (load[i]),
            .din     (din),
            .data    (data[i]),
            .ack     (ack[i])
        );
    end

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            state      <= S_IDLE;
            gnt        <= G_NONE;
            rr         <= 1'b0;
            cnt        <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick != G_NONE) begin
                        gnt        <= pick;
                        mem_addr_q <= pick_addr;
                        mem_req_q  <= 1'b1;
                        cnt        <= '0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        tmo_q     <= !bus.mem_rdy;
                        mem_req_q <= 1'b0;
                        cnt       <= '0;
                        gnt       <= G_NONE;
                        state     <= bus.mem_rdy ? S_IDLE : S_FLUSH;
                        if (gnt == G_C) rr <= 1'b1;
                        else if (gnt == G_S) rr <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_FLUSH: begin
                    // A late reply or the flush window expiring both release the port.
                    if (bus.mem_rdy || cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.tmo      = tmo_q;
    assign bus.t_data   = data[0];
    assign bus.c_data   = data[1];
    assign bus.s_data   = data[2];
    assign bus.t_ack    = ack[0];
    assign bus.c_ack    = ack[1];
    assign bus.s_ack    = ack[2];
endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Bench for gfx_rom_arbiter: directed scenarios plus a randomized run against a
// cycle-number based transaction model of grants, replies, timeouts and flushes.
module tb_gfx_rom_arbiter;
    localparam int AW  = 21;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic clk_24M = 1'b0;
    logic nRES    = 1'b0;

    logic [2:0]          req_v  = '0;
    logic [2:0][AW-1:0]  addr_v = '0;
    logic                m_rdy  = 1'b0;
    logic [DW-1:0]       m_data = '0;

    int errs   = 0;
    int checks = 0;

    gfx_rom_if #(.AW(AW), .DW(DW)) bus ();

    gfx_rom_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk_24M (clk_24M),
        .nRES    (nRES),
        .bus     (bus)
    );

    assign bus.t_req    = req_v[0];
    assign bus.c_req    = req_v[1];
    assign bus.s_req    = req_v[2];
    assign bus.t_addr   = addr_v[0];
    assign bus.c_addr   = addr_v[1];
    assign bus.s_addr   = addr_v[2];
    assign bus.mem_rdy  = m_rdy;
    assign bus.mem_data = m_data;

    wire [2:0] ack_v = {bus.s_ack, bus.c_ack, bus.t_ack};
    logic [2:0][DW-1:0] data_v;
    assign data_v = {bus.s_data, bus.c_data, bus.t_data};

    always #5 clk_24M = ~clk_24M;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {a[10:0], a} ^ 32'h5A5A_0F0F;
    endfunction

    // Each "cycle" is observed and driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_24M);
        #1;
    endtask

    task automatic apply_reset();
        nRES   = 1'b0;
        req_v  = '0;
        addr_v = '0;
        m_rdy  = 1'b0;
        m_data = '0;
        repeat (2) @(posedge clk_24M);
        #1 nRES = 1'b1;
    endtask

    task automatic test_reset();
        nRES = 1'b0;
        tick();
        checks++; if (bus.mem_req !== 1'b0) begin errs++; $display("FAIL reset_mem_req got=%0b exp=0", bus.mem_req); end
        checks++; if (bus.mem_addr !== '0) begin errs++; $display("FAIL reset_mem_addr got=%0h exp=0", bus.mem_addr); end
        checks++; if (ack_v !== 3'b000 || bus.tmo !== 1'b0) begin errs++; $display("FAIL reset_ack_tmo got=%b/%b exp=000/0", ack_v, bus.tmo); end
        checks++; if (data_v !== '0) begin errs++; $display("FAIL reset_data got=%h exp=0", data_v); end
        nRES = 1'b1;
        m_rdy = 1'b1;  // ignored in IDLE
        tick();
        m_rdy = 1'b0;
        tick();
        checks++; if (bus.mem_req !== 1'b0 || ack_v !== 3'b000) begin errs++; $display("FAIL reset_idle got=%b/%b exp=0/000", bus.mem_req, ack_v); end
    endtask

    task automatic test_single_tile();
        apply_reset();
        req_v[0] = 1'b1; addr_v[0] = 21'h01234;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 21'h01234) begin errs++; $display("FAIL tile_req c%0d got=%b/%h exp=1/01234", k, bus.mem_req, bus.mem_addr); end
            checks++; if (ack_v !== 3'b000) begin errs++; $display("FAIL tile_early_ack c%0d got=%b exp=000", k, ack_v); end
        end
        m_rdy = 1'b1; m_data = 32'hDEADBEEF;
        tick();
        m_rdy = 1'b0; m_data = '0; req_v[0] = 1'b0;
        checks++; if (ack_v !== 3'b001 || bus.t_data !== 32'hDEADBEEF) begin errs++; $display("FAIL tile_ack got=%b/%h exp=001/deadbeef", ack_v, bus.t_data); end
        checks++; if (bus.mem_req !== 1'b0 || bus.tmo !== 1'b0) begin errs++; $display("FAIL tile_done got=%b/%b exp=0/0", bus.mem_req, bus.tmo); end
        tick();
        checks++; if (ack_v !== 3'b000 || bus.mem_req !== 1'b0) begin errs++; $display("FAIL tile_after got=%b/%b exp=000/0", ack_v, bus.mem_req); end
    endtask

    task automatic test_contention();
        int ord[6] = '{0, 1, 0, 2, 0, 1};
        apply_reset();
        req_v  = 3'b111;
        addr_v = {21'h1C0DE, 21'h0BEEF, 21'h00AA5};
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 2 == 1) begin
                checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr_v[ord[k/2]]) begin errs++; $display("FAIL cont_grant c%0d got=%b/%h exp=1/%h", k, bus.mem_req, bus.mem_addr, addr_v[ord[k/2]]); end
                checks++; if (ack_v !== 3'b000) begin errs++; $display("FAIL cont_noack c%0d got=%b exp=000", k, ack_v); end
            end else begin
                checks++; if (ack_v !== 3'(1 << ord[k/2-1]) || bus.mem_req !== 1'b0) begin errs++; $display("FAIL cont_ack c%0d got=%b/%b exp=%b/0", k, ack_v, bus.mem_req, 3'(1 << ord[k/2-1])); end
                checks++; if (data_v[ord[k/2-1]] !== memf(addr_v[ord[k/2-1]])) begin errs++; $display("FAIL cont_data c%0d got=%h exp=%h", k, data_v[ord[k/2-1]], memf(addr_v[ord[k/2-1]])); end
            end
            m_rdy  = bus.mem_req;
            m_data = memf(bus.mem_addr);
        end
        req_v = '0; m_rdy = 1'b0;
        tick(); tick();
    endtask

    task automatic test_round_robin();
        int ord[6] = '{1, 2, 1, 2, 1, 2};
        apply_reset();
        req_v  = 3'b110;
        addr_v = {21'h13579, 21'h02468, 21'h00000};
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 2 == 1) begin
                checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr_v[ord[k/2]]) begin errs++; $display("FAIL rr_grant c%0d got=%b/%h exp=1/%h", k, bus.mem_req, bus.mem_addr, addr_v[ord[k/2]]); end
            end else begin
                checks++; if (ack_v !== 3'(1 << ord[k/2-1])) begin errs++; $display("FAIL rr_ack c%0d got=%b exp=%b", k, ack_v, 3'(1 << ord[k/2-1])); end
            end
            m_rdy  = bus.mem_req;
            m_data = memf(bus.mem_addr);
        end
        req_v = '0; m_rdy = 1'b0;
        tick(); tick();
    endtask

    task automatic test_zero_latency();
        apply_reset();
        req_v[2] = 1'b1; addr_v[2] = 21'h0F0F0;
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 21'h0F0F0) begin errs++; $display("FAIL zl_grant got=%b/%h exp=1/0f0f0", bus.mem_req, bus.mem_addr); end
        m_rdy = 1'b1; m_data = memf(21'h0F0F0);
        req_v[1] = 1'b1; addr_v[1] = 21'h10101;
        tick();
        m_rdy = 1'b0; req_v[2] = 1'b0;
        checks++; if (ack_v !== 3'b100 || bus.s_data !== memf(21'h0F0F0) || bus.mem_req !== 1'b0) begin errs++; $display("FAIL zl_ack got=%b/%h/%b exp=100/%h/0", ack_v, bus.s_data, bus.mem_req, memf(21'h0F0F0)); end
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 21'h10101 || ack_v !== 3'b000) begin errs++; $display("FAIL zl_next got=%b/%h/%b exp=1/10101/000", bus.mem_req, bus.mem_addr, ack_v); end
        m_rdy = 1'b1; m_data = memf(21'h10101);
        tick();
        m_rdy = 1'b0; req_v[1] = 1'b0;
        checks++; if (ack_v !== 3'b010 || bus.c_data !== memf(21'h10101)) begin errs++; $display("FAIL zl_ack2 got=%b/%h exp=010/%h", ack_v, bus.c_data, memf(21'h10101)); end
        tick(); tick();
    endtask

    task automatic test_timeout();
        apply_reset();
        req_v[1] = 1'b1; addr_v[1] = 21'h1F00D;
        for (int k = 1; k <= TMO; k++) begin
            tick();
            checks++; if (bus.mem_req !== 1'b1 || ack_v !== 3'b000 || bus.tmo !== 1'b0) begin errs++; $display("FAIL tmo_wait c%0d got=%b/%b/%b exp=1/000/0", k, bus.mem_req, ack_v, bus.tmo); end
        end
        tick();
        checks++; if (ack_v !== 3'b010 || bus.tmo !== 1'b1) begin errs++; $display("FAIL tmo_abort got=%b/%b exp=010/1", ack_v, bus.tmo); end
        checks++; if (bus.c_data !== 32'hFFFF_FFFF || bus.mem_req !== 1'b0) begin errs++; $display("FAIL tmo_data got=%h/%b exp=ffffffff/0", bus.c_data, bus.mem_req); end
        req_v[1] = 1'b0; req_v[0] = 1'b1; addr_v[0] = 21'h00777;
        tick();
        m_rdy = 1'b1; m_data = 32'h1234_5678;  // late reply lands in FLUSH
        checks++; if (bus.mem_req !== 1'b0 || bus.tmo !== 1'b0 || ack_v !== 3'b000) begin errs++; $display("FAIL tmo_flush got=%b/%b/%b exp=0/0/000", bus.mem_req, bus.tmo, ack_v); end
        tick();
        m_rdy = 1'b0;
        checks++; if (bus.mem_req !== 1'b0 || ack_v !== 3'b000) begin errs++; $display("FAIL tmo_late got=%b/%b exp=0/000", bus.mem_req, ack_v); end
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 21'h00777) begin errs++; $display("FAIL tmo_resume got=%b/%h exp=1/00777", bus.mem_req, bus.mem_addr); end
        checks++; if (bus.t_data !== '0 || bus.c_data !== 32'hFFFF_FFFF) begin errs++; $display("FAIL tmo_hold got=%h/%h exp=0/ffffffff", bus.t_data, bus.c_data); end
        m_rdy = 1'b1; m_data = memf(21'h00777);
        tick();
        m_rdy = 1'b0; req_v = '0;
        checks++; if (ack_v !== 3'b001 || bus.t_data !== memf(21'h00777)) begin errs++; $display("FAIL tmo_next got=%b/%h exp=001/%h", ack_v, bus.t_data, memf(21'h00777)); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        req_v[0] = 1'b1; addr_v[0] = 21'h0ABCD;
        tick();
        m_rdy = 1'b1; m_data = 32'hCAFE_F00D;
        tick();
        m_rdy = 1'b0; req_v[0] = 1'b0; req_v[1] = 1'b1; addr_v[1] = 21'h05555;
        checks++; if (bus.t_data !== 32'hCAFE_F00D) begin errs++; $display("FAIL rst_pre got=%h exp=cafef00d", bus.t_data); end
        tick(); tick();
        checks++; if (bus.mem_req !== 1'b1) begin errs++; $display("FAIL rst_inflight got=%b exp=1", bus.mem_req); end
        nRES = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== '0) begin errs++; $display("FAIL rst_async got=%b/%h exp=0/0", bus.mem_req, bus.mem_addr); end
        checks++; if (data_v !== '0) begin errs++; $display("FAIL rst_data got=%h exp=0", data_v); end
        req_v = '0;
        @(posedge clk_24M);
        #1 nRES = 1'b1;
        m_rdy = 1'b1; m_data = 32'h7777_7777;
        tick();
        m_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (ack_v !== 3'b000 || bus.mem_req !== 1'b0 || bus.tmo !== 1'b0 || data_v !== '0) begin errs++; $display("FAIL rst_after c%0d got=%b/%b/%b/%h exp=000/0/0/0", k, ack_v, bus.mem_req, bus.tmo, data_v); end
            tick();
        end
    endtask

    task automatic test_random();
        int  ack_at = -100, free_at = 0, rdy_at = -1, late_at = -1, g_start = -100;
        int  g_id = 0, w;
        bit  g_to = 1'b0, rr_m = 1'b0, exp_mreq;
        int  drop_at[3] = '{-1, -1, -1};
        logic [AW-1:0]      g_addr = '0;
        logic [2:0][DW-1:0] exp_d = '0;
        logic [2:0]         exp_ack, elig;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            exp_ack = (c == ack_at) ? 3'(1 << g_id) : 3'b000;
            if (c == ack_at) begin
                exp_d[g_id] = g_to ? '1 : memf(g_addr);
                if (g_id == 1) rr_m = 1'b1;
                else if (g_id == 2) rr_m = 1'b0;
            end
            exp_mreq = (c >= g_start) && (c < ack_at);
            checks++; if (bus.mem_req !== exp_mreq) begin errs++; $display("FAIL rnd_mreq c%0d got=%b exp=%b", c, bus.mem_req, exp_mreq); end
            if (exp_mreq) begin
                checks++; if (bus.mem_addr !== g_addr) begin errs++; $display("FAIL rnd_addr c%0d got=%h exp=%h", c, bus.mem_addr, g_addr); end
            end
            checks++; if (ack_v !== exp_ack) begin errs++; $display("FAIL rnd_ack c%0d got=%b exp=%b", c, ack_v, exp_ack); end
            checks++; if (bus.tmo !== (c == ack_at && g_to)) begin errs++; $display("FAIL rnd_tmo c%0d got=%b exp=%b", c, bus.tmo, (c == ack_at && g_to)); end
            checks++; if (data_v !== exp_d) begin errs++; $display("FAIL rnd_data c%0d got=%h exp=%h", c, data_v, exp_d); end

            // Requesters: usually drop one cycle after their ack, sometimes stay held,
            // occasionally cancel (before or after grant), and re-raise at random.
            for (int x = 0; x < 3; x++) begin
                if (c == ack_at && x == g_id && $urandom_range(0, 2) != 0) drop_at[x] = c + 1;
                if (drop_at[x] == c) begin
                    req_v[x] = 1'b0; drop_at[x] = -1;
                end else if (!req_v[x]) begin
                    if ($urandom_range(0, 3) == 0) begin req_v[x] = 1'b1; addr_v[x] = AW'($urandom); end
                end else if ($urandom_range(0, 29) == 0) begin
                    req_v[x] = 1'b0;
                end
            end

            // Memory: scheduled reply, late reply in flush, or a stray pulse while idle.
            m_rdy  = (c == rdy_at) || (c == late_at) ||
                     (!(c >= g_start && c < free_at) && $urandom_range(0, 7) == 0);
            m_data = (c == rdy_at) ? memf(g_addr) : DW'($urandom);

            if (c >= free_at) begin
                elig = req_v & ~exp_ack;
                w = -1;
                if (elig[0]) w = 0;
                else if (elig[1] && elig[2]) w = rr_m ? 2 : 1;
                else if (elig[1]) w = 1;
                else if (elig[2]) w = 2;
                if (w >= 0) begin
                    g_id = w; g_addr = addr_v[w]; g_start = c + 1;
                    if ($urandom_range(0, 9) < 7) begin
                        g_to = 1'b0; rdy_at = g_start + int'($urandom_range(0, TMO - 1));
                        ack_at = rdy_at + 1; free_at = ack_at; late_at = -1;
                    end else begin
                        g_to = 1'b1; rdy_at = -1; ack_at = g_start + TMO;
                        if ($urandom_range(0, 1) == 1) begin
                            late_at = ack_at + int'($urandom_range(0, TMO - 1)); free_at = late_at + 1;
                        end else begin
                            late_at = -1; free_at = ack_at + TMO;
                        end
                    end
                end
            end
            tick();
        end
        req_v = '0; m_rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_contention();
        test_round_robin();
        test_zero_latency();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
